// File: rtl/border_feed_ctrl.sv
// rtl/border_feed_ctrl.sv - left-edge border register sequencer for the systolic array
// Drives per-row en/clr with diagonal skew, zero-fills finished rows, then drains.
module border_feed_ctrl #(
    parameter int ROWS      = 8,
    parameter int CNT_W     = 8,
    parameter int DRAIN_CYC = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] k_len,
    input  logic             abort,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [ROWS-1:0]  en,
    output logic [ROWS-1:0]  clr,
    output logic             busy,
    output logic             done
);

    localparam int TW = CNT_W + $clog2(ROWS) + 1;
    localparam int DW = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
    localparam logic [DW-1:0] DLAST = DW'((DRAIN_CYC > 0) ? DRAIN_CYC - 1 : 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR,
        S_FEED,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t           state, state_n;
    logic [TW-1:0]    t, t_n;
    logic [CNT_W-1:0] klen_q, klen_n;
    logic [DW-1:0]    dcnt, dcnt_n;
    logic [TW-1:0]    klen_ext;
    logic [TW-1:0]    last_t;

    assign klen_ext = TW'(klen_q);
    assign last_t   = klen_ext + TW'(ROWS - 1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= S_IDLE;
            t      <= '0;
            klen_q <= '0;
            dcnt   <= '0;
        end else begin
            state  <= state_n;
            t      <= t_n;
            klen_q <= klen_n;
            dcnt   <= dcnt_n;
        end
    end

    always_comb begin
        state_n  = state;
        t_n      = t;
        klen_n   = klen_q;
        dcnt_n   = dcnt;
        in_ready = 1'b0;
        en       = '0;
        clr      = '0;
        busy     = (state != S_IDLE);
        done     = 1'b0;

        case (state)
            S_IDLE: begin
                if (start) begin
                    if (k_len != '0) begin
                        klen_n  = k_len;
                        state_n = S_CLR;
                    end else begin
                        state_n = S_DONE;
                    end
                end
            end
            S_CLR: begin
                clr = '1;
                if (abort) begin
                    state_n = S_IDLE;
                end else begin
                    t_n     = '0;
                    state_n = S_FEED;
                end
            end
            S_FEED: begin
                if (abort) begin
                    clr     = '1;
                    state_n = S_IDLE;
                end else begin
                    in_ready = 1'b1;
                    if (in_valid) begin
                        // Row r sees element t-r; it is zero-filled the step after its last element.
                        for (int r = 0; r < ROWS; r++) begin
                            en[r]  = (t >= TW'(r)) && (t < TW'(r) + klen_ext);
                            clr[r] = (t == TW'(r) + klen_ext);
                        end
                        t_n = t + TW'(1);
                        if (t == last_t) begin
                            dcnt_n  = '0;
                            state_n = (DRAIN_CYC == 0) ? S_DONE : S_DRAIN;
                        end
                    end
                end
            end
            S_DRAIN: begin
                if (abort) begin
                    clr     = '1;
                    state_n = S_IDLE;
                end else if (dcnt == DLAST) begin
                    state_n = S_DONE;
                end else begin
                    dcnt_n = dcnt + DW'(1);
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_border_feed_ctrl.sv
// tb/tb_border_feed_ctrl.sv - scoreboard bench for border_feed_ctrl
// Stimulus pushes expected per-cycle outputs; a negedge monitor pops and compares.
module tb_border_feed_ctrl;

    localparam int R  = 4;
    localparam int CW = 8;
    localparam int D  = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [CW-1:0] k_len;
    logic          abort;
    logic          in_valid;
    logic          in_ready;
    logic [R-1:0]  en;
    logic [R-1:0]  clr;
    logic          busy;
    logic          done;

    int tests = 0;
    int fails = 0;
    bit mon_on = 1'b1;

    typedef struct packed {
        logic [R-1:0] en;
        logic [R-1:0] clr;
        logic         ir;
        logic         busy;
        logic         done;
    } rec_t;

    rec_t exp_q[$];

    border_feed_ctrl #(.ROWS(R), .CNT_W(CW), .DRAIN_CYC(D)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .k_len    (k_len),
        .abort    (abort),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .en       (en),
        .clr      (clr),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s got=%h exp=%h at %0t", name, got, want, $time);
        end
    endtask

    function automatic rec_t mk(input logic [R-1:0] e, input logic [R-1:0] c,
                                input logic ir, input logic b, input logic d);
        rec_t x;
        x.en = e; x.clr = c; x.ir = ir; x.busy = b; x.done = d;
        return x;
    endfunction

    // Step s of a tile of k elements: row r consumes element s-r, and is
    // zero-filled on the step right after it consumed element k-1.
    function automatic rec_t step_rec(input int s, input int k);
        logic [R-1:0] e, c;
        e = '0;
        c = '0;
        for (int r = 0; r < R; r++) begin
            if (s - r >= 0 && s - r < k) e[r] = 1'b1;
            if (s - k == r) c[r] = 1'b1;
        end
        return mk(e, c, 1'b1, 1'b1, 1'b0);
    endfunction

    always @(negedge clk) begin
        if (mon_on && !rst && (busy || done)) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_output got=%h exp=none at %0t",
                         {en, clr, in_ready, busy, done}, $time);
            end else begin
                rec_t e;
                e = exp_q.pop_front();
                chk("cycle_outputs", 32'({en, clr, in_ready, busy, done}), 32'(e));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        start = 1'b0;
        abort = 1'b0;
        for (int i = 0; i < n; i++) begin
            in_valid = 1'($urandom_range(1));
            tick();
        end
    endtask

    task automatic run_tile(input int k, input int stall_pct, input int abort_step, input bit spam);
        int s, guard;
        bit iv;
        start    = 1'b1;
        k_len    = CW'(k);
        abort    = 1'($urandom_range(1));
        in_valid = 1'($urandom_range(1));
        tick();
        abort = 1'b0;
        start = spam;
        k_len = CW'($urandom);
        if (k == 0) begin
            exp_q.push_back(mk('0, '0, 1'b0, 1'b1, 1'b1));
            in_valid = 1'($urandom_range(1));
            tick();
            start = 1'b0;
            return;
        end
        exp_q.push_back(mk('0, '1, 1'b0, 1'b1, 1'b0));
        tick();
        s = 0;
        guard = 0;
        while (s < k + R && guard < 2000) begin
            iv       = ($urandom_range(99) >= stall_pct);
            in_valid = iv;
            start    = spam ? 1'($urandom_range(1)) : 1'b0;
            k_len    = CW'($urandom);
            if (iv && s == abort_step) begin
                abort = 1'b1;
                exp_q.push_back(mk('0, '1, 1'b0, 1'b1, 1'b0));
                tick();
                abort = 1'b0;
                start = 1'b0;
                return;
            end
            exp_q.push_back(iv ? step_rec(s, k) : mk('0, '0, 1'b1, 1'b1, 1'b0));
            tick();
            if (iv) s++;
            guard++;
        end
        if (guard >= 2000) chk("feed_guard", 32'(guard), 32'(0));
        for (int i = 0; i < D; i++) begin
            in_valid = 1'($urandom_range(1));
            exp_q.push_back(mk('0, '0, 1'b0, 1'b1, 1'b0));
            tick();
        end
        abort = 1'($urandom_range(1));
        exp_q.push_back(mk('0, '0, 1'b0, 1'b1, 1'b1));
        tick();
        abort = 1'b0;
        start = 1'b0;
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        k_len    = '0;
        abort    = 1'b0;
        in_valid = 1'b0;
        #2;
        chk("reset_en",       32'(en),       32'(0));
        chk("reset_clr",      32'(clr),      32'(0));
        chk("reset_busy",     32'(busy),     32'(0));
        chk("reset_done",     32'(done),     32'(0));
        chk("reset_in_ready", 32'(in_ready), 32'(0));
        @(negedge clk);
        rst = 1'b0;
        tick();

        run_tile(3, 0, -1, 1'b0);
        idle(2);
        run_tile(3, 25, -1, 1'b0);
        idle(1);
        run_tile(0, 0, -1, 1'b1);
        idle(1);
        run_tile(3, 0, -1, 1'b1);
        idle(0);
        run_tile(3, 0, 2, 1'b0);
        idle(1);

        // Asynchronous reset in the middle of FEED, outside the scoreboard.
        mon_on   = 1'b0;
        start    = 1'b1;
        k_len    = CW'(3);
        in_valid = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        rst = 1'b1;
        #1;
        chk("arst_en",       32'(en),       32'(0));
        chk("arst_clr",      32'(clr),      32'(0));
        chk("arst_busy",     32'(busy),     32'(0));
        chk("arst_in_ready", 32'(in_ready), 32'(0));
        chk("arst_done",     32'(done),     32'(0));
        #1;
        rst    = 1'b0;
        mon_on = 1'b1;
        tick();
        run_tile(3, 0, -1, 1'b0);
        idle(1);

        for (int n = 0; n < 40; n++) begin
            run_tile($urandom_range(0, 6), $urandom_range(0, 40),
                     ($urandom_range(4) == 0) ? $urandom_range(0, 8) : -1,
                     1'($urandom_range(1)));
            idle($urandom_range(0, 2));
        end
        run_tile(255, 10, -1, 1'b0);
        idle(3);

        chk("scoreboard_drained", 32'(exp_q.size()), 32'(0));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
